// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling driven by a
// per-bit cycle counter, framing-error detection and break suppression.
module uart_rx #(
    parameter int FREQ = 12000000,
    parameter int BAUD = 9600,
    parameter int LIM  = FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (LIM > 1) ? $clog2(LIM) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(LIM / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LIM - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_out_q;
    logic            data_valid_q;
    logic            frame_err_q;
    logic            busy_q;
    logic            rx_meta_q;
    logic            rx_s_q;

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

    // busy_q is written alongside every state transition so it always mirrors state_q != IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
                            state_q      <= IDLE;
                            busy_q       <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                WAIT_HIGH: begin
                    // A held-low line (break) must not be decoded as a stream of 0x00 frames.
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; expected events come from a
// frame-level model (byte in -> valid/error event out), not from the RTL structure.
module tb_uart_rx;

    localparam int FREQ = 1600;
    localparam int BAUD = 100;
    localparam int LIM  = FREQ / BAUD;
    localparam int LAT  = 2 + LIM / 2 + 9 * LIM;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int both_hi  = 0;

    int ev_kind[$];
    int ev_data[$];
    int ev_cyc[$];

    uart_rx #(.FREQ(FREQ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: kind 0 = data_valid, kind 1 = frame_err.
    always @(negedge clk) begin
        if (data_valid) begin
            ev_kind.push_back(0);
            ev_data.push_back(int'(data_out));
            ev_cyc.push_back(cyc);
        end
        if (frame_err) begin
            ev_kind.push_back(1);
            ev_data.push_back(int'(data_out));
            ev_cyc.push_back(cyc);
        end
        if (data_valid && frame_err) both_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (LIM) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int fall_cyc);
        fall_cyc = cyc;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        $display("frame sent byte=0x%02h stop=%0b", b, stop);
    endtask

    task automatic clear_ev();
        ev_kind.delete();
        ev_data.delete();
        ev_cyc.delete();
    endtask

    int fall0, fall1, lat, n_err_low;
    logic [7:0] rb, last_byte;
    logic       rerr;
    int exp_kind[$];
    int exp_data[$];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        idle(5);

        // Single clean frame, with latency measured from the pin falling edge.
        clear_ev();
        send_frame(8'h53, 1'b1, fall0);
        idle(4);
        chk("f53_nev", ev_kind.size(), 1);
        if (ev_kind.size() == 1) begin
            chk("f53_kind", ev_kind[0], 0);
            chk("f53_data", ev_data[0], 32'h53);
            lat = ev_cyc[0] - (fall0 + 1);
            chk("f53_latency", (lat >= LAT - 1 && lat <= LAT + 1), 1);
        end
        chk("f53_data_out", data_out, 8'h53);
        chk("f53_busy_after", busy, 0);

        // Short low glitch: false start, no events.
        clear_ev();
        rx = 1'b0;
        repeat (LIM / 4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("glitch_busy_mid", busy, 1);
        idle(LIM);
        chk("glitch_nev", ev_kind.size(), 0);
        chk("glitch_data_out", data_out, 8'h53);
        chk("glitch_busy_after", busy, 0);

        // Stop bit low followed by a break: one frame error, then wait for high.
        clear_ev();
        send_frame(8'h61, 1'b0, fall0);
        rx = 1'b0;
        repeat (3 * LIM) @(posedge clk);
        #1;
        chk("ferr_busy_low", busy, 1);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("ferr_busy_after", busy, 0);
        chk("ferr_nev", ev_kind.size(), 1);
        if (ev_kind.size() == 1) chk("ferr_kind", ev_kind[0], 1);
        chk("ferr_data_out", data_out, 8'h53);

        // Back-to-back frames with zero idle gap.
        clear_ev();
        send_frame(8'h6E, 1'b1, fall0);
        send_frame(8'h70, 1'b1, fall1);
        idle(4);
        chk("b2b_nev", ev_kind.size(), 2);
        if (ev_kind.size() == 2) begin
            chk("b2b_data0", ev_data[0], 32'h6E);
            chk("b2b_data1", ev_data[1], 32'h70);
            chk("b2b_spacing", ev_cyc[1] - ev_cyc[0], 10 * LIM);
        end

        // Reset pulse during data bit 4 of 0x53 aborts the frame silently.
        clear_ev();
        rb = 8'h53;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(rb[i]);
        rx = rb[4];
        repeat (LIM / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_data_out", data_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", data_valid, 0);
        chk("abort_ferr", frame_err, 0);
        idle(2 * LIM);
        chk("abort_nev", ev_kind.size(), 0);
        send_frame(8'h70, 1'b1, fall0);
        idle(4);
        chk("abort_next_nev", ev_kind.size(), 1);
        if (ev_kind.size() == 1) chk("abort_next_data", ev_data[0], 32'h70);
        chk("abort_next_data_out", data_out, 8'h70);

        // All-zero and all-one payloads.
        clear_ev();
        send_frame(8'h00, 1'b1, fall0);
        idle(LIM);
        send_frame(8'hFF, 1'b1, fall1);
        idle(4);
        chk("ext_nev", ev_kind.size(), 2);
        if (ev_kind.size() == 2) begin
            chk("ext_kind0", ev_kind[0], 0);
            chk("ext_data0", ev_data[0], 32'h00);
            chk("ext_kind1", ev_kind[1], 0);
            chk("ext_data1", ev_data[1], 32'hFF);
        end

        // Random frames: model maps each frame to one event by its stop bit value.
        clear_ev();
        last_byte = 8'hFF;
        for (int f = 0; f < 30; f++) begin
            rb   = 8'($urandom);
            rerr = ($urandom_range(0, 9) == 0);
            send_frame(rb, !rerr, fall0);
            if (rerr) begin
                exp_kind.push_back(1);
                exp_data.push_back(int'(last_byte));
                n_err_low = $urandom_range(0, 2 * LIM);
                rx = 1'b0;
                repeat (n_err_low) @(posedge clk);
                #1;
                idle(LIM + $urandom_range(0, LIM));
            end else begin
                exp_kind.push_back(0);
                exp_data.push_back(int'(rb));
                last_byte = rb;
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, LIM));
            end
        end
        idle(4);
        chk("rand_nev", ev_kind.size(), exp_kind.size());
        if (ev_kind.size() == exp_kind.size()) begin
            for (int i = 0; i < exp_kind.size(); i++) begin
                chk($sformatf("rand_kind%0d", i), ev_kind[i], exp_kind[i]);
                chk($sformatf("rand_data%0d", i), ev_data[i], exp_data[i]);
            end
        end
        chk("rand_data_out", data_out, last_byte);
        chk("never_both_high", both_hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
